// File: rtl/bcd_counter_pkg.sv
// Shared BCD digit type, digit limits and a validity helper for the counter.
package bcd_counter_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t DIGIT_MAX = 4'd9;
    localparam bcd_digit_t DIGIT_MIN = 4'd0;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: load, wrap-around step up/down, and boundary flags.
module bcd_digit_cell
    import bcd_counter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  bcd_digit_t i_load_val,
    input  logic       i_step_en,
    input  logic       i_up,
    output bcd_digit_t o_digit,
    output logic       o_at_max,
    output logic       o_at_min
);

    bcd_digit_t r_digit;

    // Non-BCD load data is replaced by 0 so a digit never holds 10..15.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digit <= DIGIT_MIN;
        end else if (i_load) begin
            r_digit <= is_bcd(i_load_val) ? i_load_val : DIGIT_MIN;
        end else if (i_step_en) begin
            if (i_up) begin
                r_digit <= (r_digit == DIGIT_MAX) ? DIGIT_MIN : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == DIGIT_MIN) ? DIGIT_MAX : r_digit - 4'd1;
            end
        end
    end

    assign o_digit  = r_digit;
    assign o_at_max = (r_digit == DIGIT_MAX);
    assign o_at_min = (r_digit == DIGIT_MIN);

endmodule

// File: rtl/multi_digit_bcd_counter.sv
// Cascaded up/down BCD counter with parallel load and sticky bad-data flag.
// Define COUNTER_SATURATE_EN to hold at all-9s / all-0s instead of wrapping.
module multi_digit_bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  err
);

    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_min;
    logic [DIGITS-1:0] w_up_chain;
    logic [DIGITS-1:0] w_dn_chain;
    logic [DIGITS-1:0] w_step_en;
    logic [DIGITS-1:0] w_bad;
    logic              w_all_max;
    logic              w_all_min;
    logic              w_at_end;
    logic              w_cnt_en;
    logic              r_err;

    assign w_all_max = &w_at_max;
    assign w_all_min = &w_at_min;
    assign w_at_end  = up ? w_all_max : w_all_min;

`ifdef COUNTER_SATURATE_EN
    assign w_cnt_en = en & ~w_at_end;
`else
    assign w_cnt_en = en;
`endif

    // Ripple enable: digit k steps only when every lower digit is at its boundary.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_first
            assign w_up_chain[k] = w_cnt_en;
            assign w_dn_chain[k] = w_cnt_en;
        end else begin : g_rest
            assign w_up_chain[k] = w_up_chain[k-1] & w_at_max[k-1];
            assign w_dn_chain[k] = w_dn_chain[k-1] & w_at_min[k-1];
        end

        assign w_step_en[k] = up ? w_up_chain[k] : w_dn_chain[k];
        assign w_bad[k]     = ~is_bcd(din[4*k +: 4]);

        bcd_digit_cell u_cell (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_load     (load),
            .i_load_val (din[4*k +: 4]),
            .i_step_en  (w_step_en[k]),
            .i_up       (up),
            .o_digit    (q[4*k +: 4]),
            .o_at_max   (w_at_max[k]),
            .o_at_min   (w_at_min[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (load && (|w_bad)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
    assign tc  = en & ~load & w_at_end;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Bench for multi_digit_bcd_counter: directed vector table plus a randomized run vs. an integer model.
module tb_multi_digit_bcd_counter;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = (10 ** DIGITS) - 1;
`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, en, up, load;
    logic [W-1:0] din;
    logic [W-1:0] q;
    logic         tc, err;

    always #5 clk = ~clk;

    multi_digit_bcd_counter #(.DIGITS(DIGITS)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .q    (q),
        .tc   (tc),
        .err  (err)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit digit_chk_on = 1'b0;

    typedef struct {
        string        name;
        logic         r, l, e, u;
        logic [W-1:0] d;
        logic [W-1:0] exp_q;
        logic         exp_err;
        logic         exp_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (digit_chk_on) begin
            for (int k = 0; k < DIGITS; k++) begin
                n_checks++;
                assert (q[4*k +: 4] <= 4'd9) else begin
                    n_errors++;
                    $display("FAIL digit_range: digit %0d got %0h expected <= 9 at %0t", k, q[4*k +: 4], $time);
                end
            end
        end
    end

    function automatic void add(input string n, input logic r, input logic l, input logic e,
                                input logic u, input logic [W-1:0] d, input logic [W-1:0] eq,
                                input logic eerr, input logic etc);
        vec_t v;
        v.name = n; v.r = r; v.l = l; v.e = e; v.u = u; v.d = d;
        v.exp_q = eq; v.exp_err = eerr; v.exp_tc = etc;
        vecs.push_back(v);
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int load_value(input logic [W-1:0] d, output bit bad);
        int v, scale, dig;
        v = 0; scale = 1; bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = int'(d[4*k +: 4]);
            if (dig > 9) begin
                dig = 0;
                bad = 1'b1;
            end
            v = v + dig * scale;
            scale = scale * 10;
        end
        return v;
    endfunction

    task automatic apply(input logic r, input logic l, input logic e, input logic u, input logic [W-1:0] d);
        @(negedge clk);
        rst = r; load = l; en = e; up = u; din = d;
        #1;
    endtask

    int  mv;
    bit  merr;
    bit  bad;
    bit  exp_tc;
    logic         rr, rl, re, ru;
    logic [W-1:0] rd;

    initial begin
        rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", q, 0);
        check("reset_err", err, 0);

        add("rst_over_load", 1, 1, 0, 1, 8'h45, 8'h00, 0, 0);
        add("load98",        0, 1, 0, 1, 8'h98, 8'h98, 0, 0);
        add("up98",          0, 0, 1, 1, 8'h00, 8'h99, 0, 0);
        add("up99_end",      0, 0, 1, 1, 8'h00, SAT ? 8'h99 : 8'h00, 0, 1);
        add("up_after_end",  0, 0, 1, 1, 8'h00, SAT ? 8'h99 : 8'h01, 0, SAT);
        add("hold",          0, 0, 0, 1, 8'h77, SAT ? 8'h99 : 8'h01, 0, 0);
        add("load10",        0, 1, 0, 0, 8'h10, 8'h10, 0, 0);
        add("dn10_borrow",   0, 0, 1, 0, 8'h00, 8'h09, 0, 0);
        add("dn09",          0, 0, 1, 0, 8'h00, 8'h08, 0, 0);
        add("load00_en",     0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
        add("dn00_end",      0, 0, 1, 0, 8'h00, SAT ? 8'h00 : 8'h99, 0, 1);
        add("load3C_bad",    0, 1, 0, 1, 8'h3C, 8'h30, 1, 0);
        add("load12_sticky", 0, 1, 0, 1, 8'h12, 8'h12, 1, 0);
        add("load_en55",     0, 1, 1, 1, 8'h55, 8'h55, 1, 0);
        add("rst_clr_err",   1, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        add("load46",        0, 1, 0, 1, 8'h46, 8'h46, 0, 0);
        add("up46",          0, 0, 1, 1, 8'h00, 8'h47, 0, 0);
        add("rst_mid_count", 1, 0, 1, 1, 8'h00, 8'h00, 0, 0);
        add("load99",        0, 1, 0, 1, 8'h99, 8'h99, 0, 0);
        add("en0_at99",      0, 0, 0, 1, 8'h00, 8'h99, 0, 0);
        add("dir_flip_dn",   0, 0, 1, 0, 8'h00, 8'h98, 0, 0);
        add("loadA5_bad",    0, 1, 0, 1, 8'hA5, 8'h05, 1, 0);
        add("load0F_bad",    0, 1, 0, 0, 8'h0F, 8'h00, 1, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].u, vecs[i].d);
            check({vecs[i].name, "_tc"}, tc, vecs[i].exp_tc);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_q"}, q, vecs[i].exp_q);
            check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
        end

        apply(1, 0, 0, 0, '0);
        @(posedge clk);
        #1;
        mv = 0;
        merr = 1'b0;
        digit_chk_on = 1'b1;

        for (int c = 0; c < 250; c++) begin
            rr = ($urandom_range(0, 39) == 0);
            rl = ($urandom_range(0, 7) == 0);
            re = ($urandom_range(0, 3) != 0);
            ru = 1'($urandom_range(0, 1));
            rd = W'($urandom);
            if (rl && $urandom_range(0, 1) == 1)
                rd = ($urandom_range(0, 1) == 1) ? to_bcd(MAXV) : '0;

            apply(rr, rl, re, ru, rd);
            exp_tc = re && !rl && ((ru && mv == MAXV) || (!ru && mv == 0));
            check("rand_tc", tc, exp_tc);

            if (rr) begin
                mv = 0;
                merr = 1'b0;
            end else if (rl) begin
                mv = load_value(rd, bad);
                if (bad) merr = 1'b1;
            end else if (re) begin
                if (ru) mv = (mv == MAXV) ? (SAT ? mv : 0) : mv + 1;
                else    mv = (mv == 0) ? (SAT ? mv : MAXV) : mv - 1;
            end

            @(posedge clk);
            #1;
            check("rand_q", q, to_bcd(mv));
            check("rand_err", err, merr);
        end

        digit_chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_digit_bcd_counter.md
MULTI_DIGIT_BCD_COUNTER -- requirements
Module: multi_digit_bcd_counter

Interface
REQ-001 Parameter DIGITS, default 2, SHALL set the number of cascaded BCD digits (legal range 1..8).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port en, input, 1, SHALL enable counting when high.
REQ-005 Port up, input, 1, SHALL select direction: 1 = increment, 0 = decrement.
REQ-006 Port load, input, 1, SHALL request a parallel load of din.
REQ-007 Port din, input, 4*DIGITS, SHALL be the load value, digit 0 in bits [3:0].
REQ-008 Port q, output, 4*DIGITS, SHALL be the registered count, digit 0 in bits [3:0].
REQ-009 Port tc, output, 1, SHALL be the combinational terminal count: en && !load && ((up && q == all 9s) || (!up && q == all 0s)).
REQ-010 Port err, output, 1, SHALL be a registered sticky flag for non-BCD load data.

Function
REQ-011 Priority per edge SHALL be rst > load > en; with none of these active, q SHALL hold.
REQ-012 On load, each digit of q SHALL take the matching din digit when that digit is <= 9; a digit > 9 SHALL load as 0 and set err.
REQ-013 Count up, digit k SHALL increment only when en is high and all lower digits are 9; a digit at 9 that increments SHALL become 0.
REQ-014 Count down, digit k SHALL decrement only when en is high and all lower digits are 0; a digit at 0 that decrements SHALL become 9.
REQ-015 Latency SHALL be one cycle: q reflects load or count on the edge where it is sampled.
REQ-016 Without COUNTER_SATURATE_EN, all-9s + 1 SHALL wrap to all-0s, and all-0s - 1 SHALL wrap to all-9s.
REQ-017 Digits SHALL never hold values 10..15 in any reachable state.
REQ-018 A change to up in the same cycle as en SHALL take effect on that edge, with no pipeline penalty.
REQ-019 err SHALL remain set until rst; a later valid load SHALL NOT clear it.

Reset
REQ-020 On rst high at a clk edge, q SHALL become 0 and err SHALL become 0, regardless of load and en.
REQ-021 rst asserted mid-count SHALL take effect on the next edge; no partial carry SHALL survive.

Configuration
REQ-022 With macro COUNTER_SATURATE_EN defined, counting up at all-9s and counting down at all-0s SHALL hold q unchanged; tc behaviour is unchanged.
REQ-023 With COUNTER_SATURATE_EN undefined, the wrap behaviour of REQ-016 SHALL apply.

Structure
REQ-024 Package bcd_counter_pkg SHALL hold DIGIT_W = 4, DIGIT_MAX = 9, DIGIT_MIN = 0, and typedef bcd_digit_t (4-bit logic).
REQ-025 One sub-module, bcd_digit_cell, SHALL implement a single digit, instantiated DIGITS times via generate.
   - Inputs: clk, rst, load, load value, step enable, up.
   - Outputs: digit, at_max, at_min.
REQ-026 The top level SHALL form the ripple-enable chain combinationally from the at_max/at_min outputs; no internal registered carries.

Verification (DIGITS=2)
REQ-027 rst=1 with load=1, din=8'h45 -> q=8'h00, err=0 next edge.
REQ-028 load din=8'h98, then en=1 up=1 for 3 cycles -> q sequence 8'h98, 8'h99, 8'h00 (wrap), 8'h01; tc=1 only while q=8'h99.
REQ-029 load 8'h10, en=1 up=0 -> q 8'h10, 8'h09, 8'h08; with COUNTER_SATURATE_EN, load 8'h00 plus down count -> q stays 8'h00 and tc=1.
REQ-030 load din=8'h3C -> q=8'h30, err=1; then load 8'h12 -> q=8'h12, err stays 1 until rst.
REQ-031 load=1 and en=1 same cycle with din=8'h55 -> q=8'h55, no increment; rst mid-count at q=8'h47 -> q=8'h00.
REQ-032 The bench SHALL check every cycle that no digit of q exceeds 9 (assertion) across a 250-cycle random en/up/load run.
